// File: rtl/env_step_ctrl_if.sv
// Step-controller bus: action handshake, reward ROM port, step-record handshake.
// With ENV_STATS_EN defined, the episode counter and return accumulator outputs are added.
interface env_step_ctrl_if #(
    parameter int unsigned ROW_BITS   = 3,
    parameter int unsigned COL_BITS   = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_W      = 8
);
    localparam int unsigned ST_W   = ROW_BITS + COL_BITS;
    localparam int unsigned ADDR_W = ST_W + 2;

    logic                         i_start;
    logic                         i_act_valid;
    logic [1:0]                   i_action;
    logic                         o_act_ready;
    logic [ADDR_W-1:0]            o_r_addr;
    logic                         o_r_read;
    logic signed [DATA_WIDTH-1:0] i_r_data;
    logic                         o_step_valid;
    logic                         i_step_ready;
    logic [ST_W-1:0]              o_state;
    logic [1:0]                   o_action;
    logic signed [DATA_WIDTH-1:0] o_reward;
    logic [ST_W-1:0]              o_next_state;
    logic                         o_done;
    logic [CNT_W-1:0]             o_step_cnt;
    logic                         o_busy;
`ifdef ENV_STATS_EN
    logic [15:0]                  o_ep_cnt;
    logic signed [DATA_WIDTH-1:0] o_ret_acc;
`endif

    // Controller side
    modport master (
        input  i_start, i_act_valid, i_action, i_r_data, i_step_ready,
        output o_act_ready, o_r_addr, o_r_read, o_step_valid, o_state,
               o_action, o_reward, o_next_state, o_done, o_step_cnt, o_busy
`ifdef ENV_STATS_EN
        , output o_ep_cnt, o_ret_acc
`endif
    );

    // Agent / ROM / Q-update side
    modport slave (
        output i_start, i_act_valid, i_action, i_r_data, i_step_ready,
        input  o_act_ready, o_r_addr, o_r_read, o_step_valid, o_state,
               o_action, o_reward, o_next_state, o_done, o_step_cnt, o_busy
`ifdef ENV_STATS_EN
        , input o_ep_cnt, o_ret_acc
`endif
    );
endinterface

// File: rtl/env_step_ctrl.sv
// Grid-world environment step controller: accepts one action per step, reads the
// reward ROM, clamps the move at the walls and returns a step record.
// Optional: define ENV_STATS_EN for the episode counter and saturating return accumulator.
module env_step_ctrl #(
    parameter int unsigned ROW_BITS   = 3,
    parameter int unsigned COL_BITS   = 3,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned ROM_LAT    = 1,
    parameter int unsigned START_ROW  = 0,
    parameter int unsigned START_COL  = 0,
    parameter int unsigned GOAL_ROW   = 7,
    parameter int unsigned GOAL_COL   = 7,
    parameter int unsigned MAX_STEPS  = 64,
    parameter int unsigned CNT_W      = 8
) (
    input  logic           i_clk,
    input  logic           i_rst,
    env_step_ctrl_if.master bus
);
    localparam int unsigned ST_W  = ROW_BITS + COL_BITS;
    localparam int unsigned CW1   = CNT_W + 1;
    localparam int unsigned LAT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_ACT,
        S_READ,
        S_WAIT,
        S_OUT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic                start_c;
    logic                accept_c;
    logic                capture_c;
    logic                hs_c;
    logic                wait_last_c;
    logic                goal_c;
    logic                limit_c;
    logic [ROW_BITS-1:0] pos_row;
    logic [COL_BITS-1:0] pos_col;
    logic [ROW_BITS-1:0] nrow_c;
    logic [COL_BITS-1:0] ncol_c;
    logic [LAT_W-1:0]    wait_cnt;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state <= S_IDLE;
        else       state <= state_nxt;
    end

    // Next-state and step events; a start in WAIT_ACT beats a simultaneous action
    always_comb begin
        state_nxt = state;
        start_c   = 1'b0;
        accept_c  = 1'b0;
        capture_c = 1'b0;
        hs_c      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.i_start) begin
                    start_c   = 1'b1;
                    state_nxt = S_WAIT_ACT;
                end
            end
            S_WAIT_ACT: begin
                if (bus.i_start) begin
                    start_c = 1'b1;
                end else if (bus.i_act_valid && bus.o_act_ready) begin
                    accept_c  = 1'b1;
                    state_nxt = S_READ;
                end
            end
            S_READ: state_nxt = S_WAIT;
            S_WAIT: begin
                if (wait_last_c) begin
                    capture_c = 1'b1;
                    state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (bus.i_step_ready) begin
                    hs_c      = 1'b1;
                    state_nxt = bus.o_done ? S_IDLE : S_WAIT_ACT;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Wall-clamped next position and termination conditions
    always_comb begin
        nrow_c = pos_row;
        ncol_c = pos_col;
        case (bus.o_action)
            2'b00:   if (pos_col != '0) ncol_c = pos_col - COL_BITS'(1);
            2'b01:   if (pos_row != '0) nrow_c = pos_row - ROW_BITS'(1);
            2'b10:   if (pos_col != '1) ncol_c = pos_col + COL_BITS'(1);
            default: if (pos_row != '1) nrow_c = pos_row + ROW_BITS'(1);
        endcase
        goal_c      = (nrow_c == ROW_BITS'(GOAL_ROW)) && (ncol_c == COL_BITS'(GOAL_COL));
        limit_c     = (CW1'(bus.o_step_cnt) + CW1'(1)) == CW1'(MAX_STEPS);
        wait_last_c = (wait_cnt == LAT_W'(ROM_LAT - 1));
    end

    // Registered outputs, position and step counter
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pos_row           <= ROW_BITS'(START_ROW);
            pos_col           <= COL_BITS'(START_COL);
            wait_cnt          <= '0;
            bus.o_act_ready   <= 1'b0;
            bus.o_busy        <= 1'b0;
            bus.o_r_read      <= 1'b0;
            bus.o_step_valid  <= 1'b0;
            bus.o_r_addr      <= '0;
            bus.o_state       <= '0;
            bus.o_action      <= '0;
            bus.o_reward      <= '0;
            bus.o_next_state  <= '0;
            bus.o_done        <= 1'b0;
            bus.o_step_cnt    <= '0;
        end else begin
            bus.o_act_ready  <= (state_nxt == S_WAIT_ACT);
            bus.o_busy       <= (state_nxt != S_IDLE);
            bus.o_r_read     <= (state_nxt == S_READ);
            bus.o_step_valid <= (state_nxt == S_OUT);

            if (start_c) begin
                pos_row        <= ROW_BITS'(START_ROW);
                pos_col        <= COL_BITS'(START_COL);
                bus.o_step_cnt <= '0;
            end

            if (accept_c) begin
                bus.o_r_addr <= {pos_row, pos_col, bus.i_action};
                bus.o_state  <= {pos_row, pos_col};
                bus.o_action <= bus.i_action;
            end

            if (state == S_READ)      wait_cnt <= '0;
            else if (state == S_WAIT) wait_cnt <= wait_cnt + LAT_W'(1);

            if (capture_c) begin
                bus.o_reward     <= bus.i_r_data;
                bus.o_next_state <= ST_W'({nrow_c, ncol_c});
                bus.o_done       <= goal_c || limit_c;
            end

            if (hs_c) begin
                {pos_row, pos_col} <= bus.o_next_state;
                bus.o_done         <= 1'b0;
                bus.o_step_cnt     <= bus.o_done ? '0 : bus.o_step_cnt + CNT_W'(1);
            end
        end
    end

`ifdef ENV_STATS_EN
    logic signed [DATA_WIDTH:0]   sum_c;
    logic signed [DATA_WIDTH-1:0] acc_c;

    // Saturating add of the current reward into the return
    always_comb begin
        sum_c = {bus.o_ret_acc[DATA_WIDTH-1], bus.o_ret_acc}
              + {bus.o_reward[DATA_WIDTH-1], bus.o_reward};
        if (sum_c[DATA_WIDTH] != sum_c[DATA_WIDTH-1])
            acc_c = sum_c[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                      : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        else
            acc_c = sum_c[DATA_WIDTH-1:0];
    end

    // Episode counter and per-episode return
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            bus.o_ep_cnt  <= '0;
            bus.o_ret_acc <= '0;
        end else begin
            if (start_c)   bus.o_ret_acc <= '0;
            else if (hs_c) bus.o_ret_acc <= acc_c;
            if (hs_c && bus.o_done) bus.o_ep_cnt <= bus.o_ep_cnt + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_env_step_ctrl.sv
// Directed bench for env_step_ctrl: default instance (a) and a MAX_STEPS=4 instance (b)
// share all inputs; each has its own registered reward ROM model.
module tb_env_step_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        act_valid = 1'b0;
    logic [1:0]  action = 2'b00;
    logic        step_ready = 1'b0;
    logic [31:0] rom_val = '0;
    logic [31:0] rdata_a = '0;
    logic [31:0] rdata_b = '0;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    env_step_ctrl_if a ();
    env_step_ctrl_if b ();

    assign a.i_start      = start;
    assign a.i_act_valid  = act_valid;
    assign a.i_action     = action;
    assign a.i_step_ready = step_ready;
    assign a.i_r_data     = rdata_a;
    assign b.i_start      = start;
    assign b.i_act_valid  = act_valid;
    assign b.i_action     = action;
    assign b.i_step_ready = step_ready;
    assign b.i_r_data     = rdata_b;

    always @(posedge clk) if (a.o_r_read) rdata_a <= rom_val;
    always @(posedge clk) if (b.o_r_read) rdata_b <= rom_val;

    env_step_ctrl dut_a (.i_clk(clk), .i_rst(rst), .bus(a));
    env_step_ctrl #(.MAX_STEPS(4)) dut_b (.i_clk(clk), .i_rst(rst), .bus(b));

    task automatic do_start();
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic issue_action(input logic [1:0] act, input logic [31:0] rew);
        int n;
        n = 0;
        rom_val = rew; action = act; act_valid = 1'b1;
        while (!a.o_act_ready && n < 20) begin @(negedge clk); n++; end
        if (!a.o_act_ready) begin
            errors++; checks++;
            $display("FAIL accept_timeout ready=%0b exp=1", a.o_act_ready);
        end
        @(posedge clk); #1 act_valid = 1'b0;
    endtask

    task automatic wait_record();
        int n;
        n = 0;
        @(negedge clk);
        while (!a.o_step_valid && n < 20) begin @(negedge clk); n++; end
        if (!a.o_step_valid) begin
            errors++; checks++;
            $display("FAIL record_timeout valid=%0b exp=1", a.o_step_valid);
        end
    endtask

    task automatic handshake();
        step_ready = 1'b1;
        @(posedge clk); #1 step_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic step(input logic [1:0] act, input logic [31:0] rew);
        issue_action(act, rew);
        wait_record();
        handshake();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({a.o_busy, a.o_act_ready, a.o_step_valid, a.o_r_read, a.o_done} !== 5'b0) begin
            errors++; $display("FAIL reset_strobes got=%b exp=00000",
                {a.o_busy, a.o_act_ready, a.o_step_valid, a.o_r_read, a.o_done});
        end
        checks++;
        if ({a.o_r_addr, a.o_state, a.o_next_state, a.o_action, a.o_step_cnt, a.o_reward} !== '0) begin
            errors++; $display("FAIL reset_fields addr=%h st=%o nst=%o cnt=%0d rew=%h exp=all 0",
                a.o_r_addr, a.o_state, a.o_next_state, a.o_step_cnt, a.o_reward);
        end
        @(negedge clk); rst = 1'b0;
        act_valid = 1'b1; action = 2'b10;
        repeat (3) @(negedge clk);
        checks++;
        if ({a.o_busy, a.o_act_ready, a.o_r_read} !== 3'b000) begin
            errors++; $display("FAIL idle_ignores_action got=%b exp=000",
                {a.o_busy, a.o_act_ready, a.o_r_read});
        end
        act_valid = 1'b0;
    endtask

`ifdef ENV_STATS_EN
    task automatic test_stats();
        do_start();
        step(2'b10, 32'hFFFFFFFB); step(2'b10, 32'hFFFFFFFB);
        step(2'b11, 32'hFFFFFFFB); step(2'b11, 32'hFFFFFFFB);
        checks++;
        if ({b.o_ep_cnt, b.o_ret_acc, b.o_busy} !== {16'd1, 32'hFFFFFFEC, 1'b0}) begin
            errors++; $display("FAIL stats_ep1 ep=%0d ret=%h busy=%0b exp ep=1 ret=ffffffec busy=0",
                b.o_ep_cnt, b.o_ret_acc, b.o_busy);
        end
        do_start();
        checks++;
        if (b.o_ret_acc !== 32'h0) begin
            errors++; $display("FAIL stats_clear ret=%h exp=0", b.o_ret_acc);
        end
        step(2'b10, 32'd2); step(2'b10, 32'd1); step(2'b11, 32'd1); step(2'b11, 32'd1);
        checks++;
        if ({b.o_ep_cnt, b.o_ret_acc} !== {16'd2, 32'd5}) begin
            errors++; $display("FAIL stats_ep2 ep=%0d ret=%h exp ep=2 ret=5", b.o_ep_cnt, b.o_ret_acc);
        end
        do_start();
        step(2'b10, 32'h7FFFFFF0); step(2'b10, 32'h00000100); step(2'b11, 32'd1);
        checks++;
        if (a.o_ret_acc !== 32'h7FFFFFFF) begin
            errors++; $display("FAIL stats_saturate ret=%h exp=7fffffff", a.o_ret_acc);
        end
    endtask
`endif

    task automatic test_max_steps();
        logic [3:0] exp_done;
        logic [1:0] acts [4];
        exp_done = 4'b1000;
        acts[0] = 2'b10; acts[1] = 2'b10; acts[2] = 2'b11; acts[3] = 2'b11;
        do_start();
        for (int k = 0; k < 4; k++) begin
            issue_action(acts[k], 32'd3);
            wait_record();
            checks++;
            if ({b.o_step_valid, b.o_done, a.o_done} !== {1'b1, exp_done[k], 1'b0}) begin
                errors++; $display("FAIL max_steps_done k=%0d got b_valid=%0b b_done=%0b a_done=%0b exp 1 %0b 0",
                    k, b.o_step_valid, b.o_done, a.o_done, exp_done[k]);
            end
            handshake();
        end
        checks++;
        if ({b.o_busy, b.o_step_cnt} !== {1'b0, 8'd0}) begin
            errors++; $display("FAIL max_steps_idle busy=%0b cnt=%0d exp 0 0", b.o_busy, b.o_step_cnt);
        end
    endtask

    task automatic test_first_step();
        do_start();
        rom_val = 32'hFF000001; action = 2'b01; act_valid = 1'b1;
        @(posedge clk); #1 act_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({a.o_r_read, a.o_r_addr, a.o_step_valid} !== {1'b1, 8'h01, 1'b0}) begin
            errors++; $display("FAIL first_read rd=%0b addr=%h valid=%0b exp 1 01 0",
                a.o_r_read, a.o_r_addr, a.o_step_valid);
        end
        @(negedge clk);
        checks++;
        if ({a.o_r_read, a.o_step_valid} !== 2'b00) begin
            errors++; $display("FAIL first_wait rd=%0b valid=%0b exp 0 0", a.o_r_read, a.o_step_valid);
        end
        @(negedge clk);
        checks++;
        if ({a.o_step_valid, a.o_reward, a.o_next_state, a.o_state, a.o_action, a.o_done}
            !== {1'b1, 32'hFF000001, 6'o00, 6'o00, 2'b01, 1'b0}) begin
            errors++; $display("FAIL first_record valid=%0b rew=%h nst=%o st=%o act=%b done=%0b exp 1 ff000001 00 00 01 0",
                a.o_step_valid, a.o_reward, a.o_next_state, a.o_state, a.o_action, a.o_done);
        end
        handshake();
        checks++;
        if (a.o_step_cnt !== 8'd1) begin
            errors++; $display("FAIL first_cnt got=%0d exp=1", a.o_step_cnt);
        end
    endtask

    task automatic test_move_mid();
        do_start();
        repeat (3) step(2'b11, 32'd0);
        repeat (4) step(2'b10, 32'd0);
        checks++;
        if (a.o_step_cnt !== 8'd7) begin
            errors++; $display("FAIL walk_cnt got=%0d exp=7", a.o_step_cnt);
        end
        issue_action(2'b11, 32'd0);
        @(negedge clk);
        checks++;
        if (a.o_r_addr !== 8'b011_100_11) begin
            errors++; $display("FAIL mid_addr got=%h exp=73", a.o_r_addr);
        end
        wait_record();
        checks++;
        if ({a.o_next_state, a.o_state, a.o_reward, a.o_done} !== {6'o44, 6'o34, 32'd0, 1'b0}) begin
            errors++; $display("FAIL mid_record nst=%o st=%o rew=%h done=%0b exp 44 34 0 0",
                a.o_next_state, a.o_state, a.o_reward, a.o_done);
        end
        handshake();
        checks++;
        if (a.o_step_cnt !== 8'd8) begin
            errors++; $display("FAIL mid_cnt got=%0d exp=8", a.o_step_cnt);
        end
    endtask

    task automatic test_goal();
        repeat (3) step(2'b11, 32'd0);
        issue_action(2'b11, 32'd9);
        wait_record();
        checks++;
        if ({a.o_next_state, a.o_done} !== {6'o74, 1'b0}) begin
            errors++; $display("FAIL wall_down nst=%o done=%0b exp 74 0", a.o_next_state, a.o_done);
        end
        handshake();
        step(2'b10, 32'd0); step(2'b10, 32'd0);
        issue_action(2'b10, 32'h00FFFFFF);
        @(negedge clk);
        checks++;
        if (a.o_r_addr !== 8'hFA) begin
            errors++; $display("FAIL goal_addr got=%h exp=fa", a.o_r_addr);
        end
        wait_record();
        checks++;
        if ({a.o_next_state, a.o_reward, a.o_done, a.o_step_cnt} !== {6'o77, 32'h00FFFFFF, 1'b1, 8'd14}) begin
            errors++; $display("FAIL goal_record nst=%o rew=%h done=%0b cnt=%0d exp 77 00ffffff 1 14",
                a.o_next_state, a.o_reward, a.o_done, a.o_step_cnt);
        end
        handshake();
        checks++;
        if ({a.o_busy, a.o_act_ready, a.o_step_valid, a.o_step_cnt} !== {3'b000, 8'd0}) begin
            errors++; $display("FAIL goal_idle busy=%0b rdy=%0b valid=%0b cnt=%0d exp 0 0 0 0",
                a.o_busy, a.o_act_ready, a.o_step_valid, a.o_step_cnt);
        end
    endtask

    task automatic test_backpressure();
        do_start();
        issue_action(2'b10, 32'h12345678);
        wait_record();
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            checks++;
            if ({a.o_step_valid, a.o_act_ready, a.o_state, a.o_action, a.o_next_state, a.o_reward, a.o_done}
                !== {1'b1, 1'b0, 6'o00, 2'b10, 6'o01, 32'h12345678, 1'b0}) begin
                errors++; $display("FAIL hold_record k=%0d valid=%0b rdy=%0b st=%o act=%b nst=%o rew=%h exp 1 0 00 10 01 12345678",
                    k, a.o_step_valid, a.o_act_ready, a.o_state, a.o_action, a.o_next_state, a.o_reward);
            end
        end
        handshake();
    endtask

    task automatic test_start_priority();
        start = 1'b1; act_valid = 1'b1; action = 2'b11;
        @(negedge clk); start = 1'b0; act_valid = 1'b0;
        checks++;
        if ({a.o_r_read, a.o_busy, a.o_act_ready, a.o_step_cnt} !== {3'b011, 8'd0}) begin
            errors++; $display("FAIL start_priority rd=%0b busy=%0b rdy=%0b cnt=%0d exp 0 1 1 0",
                a.o_r_read, a.o_busy, a.o_act_ready, a.o_step_cnt);
        end
        issue_action(2'b11, 32'd0);
        @(negedge clk);
        checks++;
        if (a.o_r_addr !== 8'h03) begin
            errors++; $display("FAIL restart_addr got=%h exp=03", a.o_r_addr);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_record();
        checks++;
        if ({a.o_next_state, a.o_state} !== {6'o10, 6'o00}) begin
            errors++; $display("FAIL start_in_flight nst=%o st=%o exp 10 00", a.o_next_state, a.o_state);
        end
        handshake();
        checks++;
        if (a.o_step_cnt !== 8'd1) begin
            errors++; $display("FAIL start_in_flight_cnt got=%0d exp=1", a.o_step_cnt);
        end
    endtask

    task automatic test_reset_mid();
        rom_val = 32'h55; action = 2'b10; act_valid = 1'b1;
        @(posedge clk); #1 act_valid = 1'b0;
        @(posedge clk); #1 rst = 1'b1;
        #1;
        checks++;
        if ({a.o_busy, a.o_act_ready, a.o_step_valid, a.o_r_read, a.o_done} !== 5'b0) begin
            errors++; $display("FAIL mid_reset_strobes got=%b exp=00000",
                {a.o_busy, a.o_act_ready, a.o_step_valid, a.o_r_read, a.o_done});
        end
        checks++;
        if ({a.o_r_addr, a.o_state, a.o_next_state, a.o_action, a.o_step_cnt} !== '0) begin
            errors++; $display("FAIL mid_reset_fields addr=%h st=%o nst=%o act=%b cnt=%0d exp all 0",
                a.o_r_addr, a.o_state, a.o_next_state, a.o_action, a.o_step_cnt);
        end
        @(negedge clk); rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            checks++;
            if ({a.o_step_valid, a.o_busy} !== 2'b00) begin
                errors++; $display("FAIL mid_reset_no_record k=%0d valid=%0b busy=%0b exp 0 0",
                    k, a.o_step_valid, a.o_busy);
            end
        end
    endtask

    initial begin
        test_reset();
`ifdef ENV_STATS_EN
        test_stats();
`endif
        test_max_steps();
        test_first_step();
        test_move_mid();
        test_goal();
        test_backpressure();
        test_start_priority();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
